// File: rtl/ram_bist_pkg.sv
// Shared types and march-element table for the RAM march-test BIST.
package ram_bist_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StRd,
    StCmp,
    StDone
  } state_e;

  typedef logic [1:0] elem_t;

  localparam elem_t LastElem = 2'd3;

  // down: descending address order; *_val: 0 selects PATTERN, 1 selects ~PATTERN.
  typedef struct packed {
    logic down;
    logic has_read;
    logic read_val;
    logic has_write;
    logic write_val;
  } elem_cfg_t;

  // M0: up W0 / M1: up R0,W1 / M2: down R1,W0 / M3: up R0
  function automatic elem_cfg_t elem_cfg(elem_t e);
    elem_cfg_t cfg;
    unique case (e)
      2'd0:    cfg = '{down: 1'b0, has_read: 1'b0, read_val: 1'b0, has_write: 1'b1, write_val: 1'b0};
      2'd1:    cfg = '{down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b1, write_val: 1'b1};
      2'd2:    cfg = '{down: 1'b1, has_read: 1'b1, read_val: 1'b1, has_write: 1'b1, write_val: 1'b0};
      default: cfg = '{down: 1'b0, has_read: 1'b1, read_val: 1'b0, has_write: 1'b0, write_val: 1'b0};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with load-to-start and an explicit terminal-address flag.
module ram_bist_addr_gen #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              step_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] One = ADDR_W'(1);

  logic [ADDR_W-1:0] addr_q, addr_d;

  // Load wins over step; the start value depends on the incoming element's direction.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = down_i ? addr_q - One : addr_q + One;
    end
  end

  // Address register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_bist.sv
// March-test BIST controller: drives a single-port RAM through M0..M3 and checks read-backs.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  output logic                 wr_en_o,
  output logic                 rd_en_o,
  output logic [ADDR_W-1:0]    addr_o,
  inout  wire  [DATA_W-1:0]    data_io,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fail_o,
  output logic [ADDR_W-1:0]    fail_addr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  state_e               state_q, state_d;
  elem_t                elem_q, elem_d, elem_nxt;
  elem_cfg_t            cfg, nxt_cfg;
  logic                 fail_q, fail_d;
  logic [ADDR_W-1:0]    fail_addr_q, fail_addr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d, exp_data;
  logic                 wr_en_q, rd_en_q, busy_q, done_q;
  logic                 load, load_down, step, advance, last;
  logic [ADDR_W-1:0]    addr;

  ram_bist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .load_down_i(load_down),
    .step_i     (step),
    .down_i     (cfg.down),
    .addr_o     (addr),
    .last_o     (last)
  );

  assign elem_nxt = elem_q + 2'd1;
  assign cfg      = elem_cfg(elem_q);
  assign nxt_cfg  = elem_cfg(elem_nxt);
  assign exp_data = cfg.read_val ? ~PATTERN : PATTERN;

  // Next-state, address control and result update.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    load        = 1'b0;
    load_down   = 1'b0;
    step        = 1'b0;
    advance     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          // M0 is write-only, so every run opens with a write to address 0.
          state_d     = StWr;
          elem_d      = '0;
          load        = 1'b1;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          err_cnt_d   = '0;
        end
      end
      StWr: advance = 1'b1;
      StRd: state_d = StCmp;
      StCmp: begin
        if (data_io != exp_data) begin
          fail_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          if (!fail_q) fail_addr_d = addr;
        end
        if (cfg.has_write) state_d = StWr;
        else               advance = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Last slot of this address done: step, move to the next element, or finish.
    if (advance) begin
      if (last) begin
        if (elem_q == LastElem) begin
          state_d = StDone;
        end else begin
          elem_d    = elem_nxt;
          load      = 1'b1;
          load_down = nxt_cfg.down;
          state_d   = nxt_cfg.has_read ? StRd : StWr;
        end
      end else begin
        step    = 1'b1;
        state_d = cfg.has_read ? StRd : StWr;
      end
    end

    wr_data_d = elem_cfg(elem_d).write_val ? ~PATTERN : PATTERN;
  end

  // State, results and registered bus controls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= (state_d == StWr);
      rd_en_q     <= (state_d == StRd);
      busy_q      <= (state_d == StWr) || (state_d == StRd) || (state_d == StCmp);
      done_q      <= (state_d == StDone);
    end
  end

  // Drive the bus only during write cycles; reset releases it immediately.
  assign data_io     = wr_en_q ? wr_data_q : {DATA_W{1'bz}};
  assign wr_en_o     = wr_en_q;
  assign rd_en_o     = rd_en_q;
  assign addr_o      = addr;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist with a behavioural 256x32 RAM, stuck-bit faults and a bus monitor.
module tb_ram_bist;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        wr_en_o, rd_en_o, busy_o, done_o, fail_o;
  logic [7:0]  addr_o, fail_addr_o, err_cnt_o;
  wire  [31:0] data_io;

  ram_bist dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .wr_en_o    (wr_en_o),
    .rd_en_o    (rd_en_o),
    .addr_o     (addr_o),
    .data_io    (data_io),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fail_o     (fail_o),
    .fail_addr_o(fail_addr_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RAM with one optional stuck bit applied on read.
  logic [31:0] mem [256];
  logic [31:0] rd_q = '0;
  logic        ram_drive_q = 1'b0;
  logic        flt_en = 1'b0;
  logic [7:0]  flt_addr = '0;
  int          flt_bit = 0;
  logic        flt_val = 1'b0;

  always @(posedge clk_i) begin
    if (wr_en_o) mem[addr_o] <= data_io;
    ram_drive_q <= rd_en_o;
    if (rd_en_o) begin
      rd_q <= mem[addr_o];
      if (flt_en && addr_o == flt_addr) rd_q[flt_bit] <= flt_val;
    end
  end

  assign data_io = ram_drive_q ? rd_q : 32'hzzzz_zzzz;

  // Bus monitor: contention, floating bus, slot ordering and M2 address order.
  int         contention = 0, float_bad = 0, seq_bad = 0, order_bad = 0, rd_idx = 0;
  logic       h1_rd = 1'b0, h2_rd = 1'b0;
  logic [7:0] h1_addr = '0, h2_addr = '0;
  int         h1_idx = 0, h2_idx = 0;

  always @(negedge clk_i) begin
    if (!rst_i) begin
      h1_rd = 1'b0;
      h2_rd = 1'b0;
    end else begin
      if (wr_en_o && rd_en_o) seq_bad++;
      if (wr_en_o && ram_drive_q) contention++;
      if (!wr_en_o && !ram_drive_q && data_io !== 32'hzzzz_zzzz) float_bad++;
      if (h1_rd && (wr_en_o || rd_en_o)) seq_bad++;
      if (h2_rd && h2_idx < 512 && !(wr_en_o && addr_o == h2_addr)) seq_bad++;
      if (rd_en_o && rd_idx >= 256 && rd_idx < 512 && int'(addr_o) != 511 - rd_idx) order_bad++;
      h2_rd   = h1_rd;
      h2_addr = h1_addr;
      h2_idx  = h1_idx;
      h1_rd   = rd_en_o;
      h1_addr = addr_o;
      h1_idx  = rd_idx;
      if (rd_en_o) rd_idx++;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge; returns #1 after the start edge (cycle 1 of the run).
  task automatic do_start();
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    contention = 0;
    float_bad  = 0;
    seq_bad    = 0;
    order_bad  = 0;
    rd_idx     = 0;
  endtask

  // Count cycles from cycle 1 until done_o or stop_at; optionally pulse start mid-run.
  task automatic run_wait(input int pulse_at, input int stop_at, output int cycles);
    int n;
    n = 1;
    while (!done_o && n < stop_at) begin
      start_i = (n == pulse_at);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      n++;
    end
    cycles = n;
  endtask

  task automatic check_first_cycle(input string tag);
    check_eq({tag, "_busy"}, busy_o, 1'b1);
    check_eq({tag, "_wr_en"}, wr_en_o, 1'b1);
    check_eq({tag, "_addr0"}, addr_o, 8'h00);
    check_eq({tag, "_done_clr"}, done_o, 1'b0);
    check_eq({tag, "_fail_clr"}, fail_o, 1'b0);
    check_eq({tag, "_err_clr"}, err_cnt_o, 8'h00);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_wr_en"}, wr_en_o, 1'b0);
    check_eq({tag, "_rd_en"}, rd_en_o, 1'b0);
    check_eq({tag, "_addr"}, addr_o, 8'h00);
    check_eq({tag, "_data_z"}, data_io, 32'hzzzz_zzzz);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_done"}, done_o, 1'b0);
    check_eq({tag, "_fail"}, fail_o, 1'b0);
    check_eq({tag, "_fail_addr"}, fail_addr_o, 8'h00);
    check_eq({tag, "_err_cnt"}, err_cnt_o, 8'h00);
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;

    #22;
    check_reset_vals("por");
    @(negedge clk_i);
    rst_i = 1'b1;

    // Run A: fault-free, with an ignored mid-run start pulse.
    do_start();
    check_first_cycle("a_start");
    run_wait(1000, 3000, cyc);
    check_eq("a_cycles", cyc, 2305);
    check_eq("a_done", done_o, 1'b1);
    check_eq("a_busy", busy_o, 1'b0);
    check_eq("a_fail", fail_o, 1'b0);
    check_eq("a_err_cnt", err_cnt_o, 8'h00);
    check_eq("a_contention", contention, 0);
    check_eq("a_float", float_bad, 0);
    check_eq("a_slot_seq", seq_bad, 0);
    check_eq("a_m2_order", order_bad, 0);
    check_eq("a_rd_count", rd_idx, 768);

    // Run B: address 0x5A bit 3 stuck-at-0, only the M2 R1 read sees it.
    flt_en = 1'b1; flt_addr = 8'h5A; flt_bit = 3; flt_val = 1'b0;
    do_start();
    check_first_cycle("b_start");
    run_wait(0, 3000, cyc);
    check_eq("b_cycles", cyc, 2305);
    check_eq("b_fail", fail_o, 1'b1);
    check_eq("b_fail_addr", fail_addr_o, 8'h5A);
    check_eq("b_err_cnt", err_cnt_o, 8'h01);

    // Run C: start from DONE after a failing run; address 0x00 bit 0 stuck-at-1.
    flt_addr = 8'h00; flt_bit = 0; flt_val = 1'b1;
    do_start();
    check_first_cycle("c_start");
    run_wait(0, 3000, cyc);
    check_eq("c_cycles", cyc, 2305);
    check_eq("c_fail", fail_o, 1'b1);
    check_eq("c_fail_addr", fail_addr_o, 8'h00);
    check_eq("c_err_cnt", err_cnt_o, 8'h02);
    check_eq("c_contention", contention, 0);

    // Run D: reset in cycle 502 (an M1 write to address 81), then a clean rerun.
    flt_en = 1'b0;
    do_start();
    run_wait(0, 502, cyc);
    check_eq("d_mid_cycles", cyc, 502);
    check_eq("d_mid_wr_en", wr_en_o, 1'b1);
    check_eq("d_mid_addr", addr_o, 8'd81);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_vals("d_rst");
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    do_start();
    check_first_cycle("d_restart");
    run_wait(0, 3000, cyc);
    check_eq("d_cycles", cyc, 2305);
    check_eq("d_fail", fail_o, 1'b0);
    check_eq("d_err_cnt", err_cnt_o, 8'h00);
    check_eq("d_float", float_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
